// File: rtl/btn_io_reader_pkg.sv
// rtl/btn_io_reader_pkg.sv - shared FSM encoding and 27 MHz timing defaults for the button reader
package btn_io_reader_pkg;

    // Per-channel debounce FSM states
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_DEB_PRESS   = 2'd1,
        ST_HELD        = 2'd2,
        ST_DEB_RELEASE = 2'd3
    } btn_fsm_e;

    localparam int SYS_CLK_HZ              = 27_000_000;
    // 10 ms of stable samples before a change is accepted
    localparam int DEFAULT_DEBOUNCE_CYCLES = SYS_CLK_HZ / 100;
    // 1 s of holding before the long-press strobe
    localparam int DEFAULT_LONG_CYCLES     = SYS_CLK_HZ;

endpackage

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one button channel: 2-FF synchronizer, debounce FSM, hold timer
module btn_debounce_ch
    import btn_io_reader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic btn_n,
    output logic btn_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    // hold_cnt counts edges spent pressed since the accepted press; it
    // stops at LONG_CYCLES so the long strobe can only fire once per press
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES);

    logic sync_a;
    logic sync_s;

    btn_fsm_e          state;
    btn_fsm_e          state_nxt;
    logic [DEB_W-1:0]  deb_cnt;
    logic [DEB_W-1:0]  deb_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic [HOLD_W-1:0] hold_inc;

    logic level_nxt;
    logic press_nxt;
    logic release_nxt;
    logic long_nxt;

    // Two-flop synchronizer for the asynchronous pin; idles released (high)
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_a <= 1'b1;
            sync_s <= 1'b1;
        end else begin
            sync_a <= btn_n;
            sync_s <= sync_a;
        end
    end

    // State register: FSM, counters and registered outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state         <= ST_IDLE;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            btn_state     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            state         <= state_nxt;
            deb_cnt       <= deb_nxt;
            hold_cnt      <= hold_nxt;
            btn_state     <= level_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            long_pulse    <= long_nxt;
        end
    end

    assign hold_inc = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 1'b1;

    // Next-state logic: a change is accepted only after an unbroken run of samples
    always_comb begin
        state_nxt = state;
        deb_nxt   = deb_cnt;
        hold_nxt  = hold_cnt;
        unique case (state)
            ST_IDLE: begin
                if (!sync_s) begin
                    state_nxt = ST_DEB_PRESS;
                    deb_nxt   = '0;
                end
            end
            ST_DEB_PRESS: begin
                if (sync_s) begin
                    state_nxt = ST_IDLE;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt = ST_HELD;
                    hold_nxt  = '0;
                end else begin
                    deb_nxt = deb_cnt + 1'b1;
                end
            end
            ST_HELD: begin
                hold_nxt = hold_inc;
                if (sync_s) begin
                    state_nxt = ST_DEB_RELEASE;
                    deb_nxt   = '0;
                end
            end
            ST_DEB_RELEASE: begin
                // the hold timer keeps running so a release bounce does not restart it
                hold_nxt = hold_inc;
                if (!sync_s) begin
                    state_nxt = ST_HELD;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt = ST_IDLE;
                end else begin
                    deb_nxt = deb_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output logic: strobes decoded from the transition about to be taken
    always_comb begin
        level_nxt   = (state_nxt == ST_HELD) || (state_nxt == ST_DEB_RELEASE);
        press_nxt   = (state == ST_DEB_PRESS) && (state_nxt == ST_HELD);
        release_nxt = (state == ST_DEB_RELEASE) && (state_nxt == ST_IDLE);
        long_nxt    = ((state == ST_HELD) || (state == ST_DEB_RELEASE))
                      && (hold_cnt != HOLD_LAST) && (hold_nxt == HOLD_LAST);
    end

endmodule

// File: rtl/btn_io_reader.sv
// rtl/btn_io_reader.sv - debounced press/release/long-press events for active-low board buttons
module btn_io_reader
    import btn_io_reader_pkg::*;
#(
    parameter int NUM_BTN         = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [NUM_BTN-1:0] btn_n,
    output logic [NUM_BTN-1:0] btn_state,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] release_pulse,
    output logic [NUM_BTN-1:0] long_pulse
);

    // One fully independent channel per button (bit 0 = btn_A, bit 1 = btn_B)
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_ch (
            .sys_clk       (sys_clk),
            .sys_rst       (sys_rst),
            .btn_n         (btn_n[i]),
            .btn_state     (btn_state[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .long_pulse    (long_pulse[i])
        );
    end

endmodule
